muldiv_sequencer: RTL

//  Iterative RV32M multiply/divide unit. Sits in EX beside the ALU; decode routes
//  M-extension ops (funct7=0000001) here, and the core stalls while busy is high.

---
 rtl/muldiv_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit. One shared XLEN+1-bit add/sub per cycle,
// radix-2, fixed latency: start edge, XLEN RUN cycles, one FIN cycle, then a
// registered done pulse with the result.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic              div0_q, div0_d;
  logic [XLEN-1:0]   b_q, b_d;        // divisor / multiplicand magnitude
  logic [XLEN-1:0]   hi_q, hi_d;      // product high half / partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;      // multiplier -> product low / dividend -> quotient
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  // Operand decode at launch: signedness per funct3, then magnitudes.
  logic              in_div, in_sgn_a, in_sgn_b, in_sa, in_sb;
  logic [XLEN-1:0]   in_a_mag, in_b_mag;
  always_comb begin
    in_div   = funct3[2];
    in_sgn_a = in_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    in_sgn_b = in_div ? ~funct3[0] : ~funct3[1];
    in_sa    = in_sgn_a & rs1[XLEN-1];
    in_sb    = in_sgn_b & rs2[XLEN-1];
    in_a_mag = in_sa ? (~rs1 + XLEN'(1)) : rs1;
    in_b_mag = in_sb ? (~rs2 + XLEN'(1)) : rs2;
  end

  // The single shared add/sub: multiply adds the multiplicand when the
  // multiplier LSB is set; divide trial-subtracts the divisor.
  logic [XLEN:0] add_a, add_b, add_sum;
  logic          add_sub;
  always_comb begin
    if (f3_q[2]) begin
      add_a   = {hi_q, lo_q[XLEN-1]};
      add_b   = {1'b0, b_q};
      add_sub = 1'b1;
    end else begin
      add_a   = {1'b0, hi_q};
      add_b   = lo_q[0] ? {1'b0, b_q} : '0;
      add_sub = 1'b0;
    end
    add_sum = add_a + (add_sub ? ~add_b : add_b) + {{XLEN{1'b0}}, add_sub};
  end

  // One iteration step. Restoring divide: the remainder stays below the divisor,
  // so the MSB of the XLEN+1-bit difference is a clean "went negative" flag.
  logic [XLEN-1:0] hi_iter, lo_iter;
  always_comb begin
    if (f3_q[2]) begin
      hi_iter = add_sum[XLEN] ? add_a[XLEN-1:0] : add_sum[XLEN-1:0];
      lo_iter = {lo_q[XLEN-2:0], ~add_sum[XLEN]};
    end else begin
      hi_iter = add_sum[XLEN:1];
      lo_iter = {add_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Final sign correction and result select.
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;
  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = (sa_q ^ sb_q) ? (~prod + (2*XLEN)'(1)) : prod;
    quo_fix  = (sa_q ^ sb_q) ? (~lo_q + XLEN'(1)) : lo_q;
    if (div0_q) quo_fix = '1;
    rem_fix  = sa_q ? (~hi_q + XLEN'(1)) : hi_q;
    if (f3_q[2])              fin_res = f3_q[1] ? rem_fix : quo_fix;
    else if (f3_q == 3'b000)  fin_res = prod_fix[XLEN-1:0];
    else                      fin_res = prod_fix[2*XLEN-1:XLEN];
  end

  // Next-state and register updates for IDLE -> RUN -> FIN -> IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    div0_d   = div0_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d    = funct3;
          sa_d    = in_sa;
          sb_d    = in_sb;
          div0_d  = in_div & (rs2 == '0);
          b_d     = in_b_mag;
          hi_d    = '0;
          lo_d    = in_a_mag;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          hi_d  = hi_iter;
          lo_d  = lo_iter;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN-1)) state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        if (!flush) begin
          result_d = fin_res;
          done_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      div0_q   <= 1'b0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      div0_q   <= div0_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule
